// File: rtl/pipelined_main_control.sv
// Registered ID-stage main control for the 16-bit datapath: decodes {opcode, funct},
// resolves branches against the comparator and sequences flush, load-use stall, exception and halt.
module pipelined_main_control #(
    parameter int unsigned OP_W         = 4,
    parameter int unsigned FN_W         = 4,
    parameter int unsigned RA_W         = 4,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    input  logic [OP_W-1:0] opcode,
    input  logic [FN_W-1:0] funct,
    input  logic [1:0]      cmp,
    input  logic [RA_W-1:0] id_rs,
    input  logic [RA_W-1:0] id_rt,
    input  logic [RA_W-1:0] ex_rd,
    input  logic            exc_ack,
    output logic            ctl_alusrc1,
    output logic            ctl_alusrc2,
    output logic            ctl_memread,
    output logic            ctl_memwrite,
    output logic            ctl_memtoreg,
    output logic            ctl_strbyte,
    output logic            ctl_upperzero,
    output logic [1:0]      ctl_aluop,
    output logic [1:0]      ctl_regwrite,
    output logic [1:0]      ctl_signext,
    output logic            pc_write,
    output logic            ifid_write,
    output logic            ifid_flush,
    output logic            branch,
    output logic            exception,
    output logic            halted
);

    typedef enum logic [2:0] {
        S_RUN,
        S_STALL,
        S_FLUSH,
        S_EXC,
        S_HALTED
    } state_t;

    typedef struct packed {
        logic       alusrc1;
        logic       alusrc2;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       strbyte;
        logic       upperzero;
        logic [1:0] aluop;
        logic [1:0] regwrite;
        logic [1:0] signext;
    } ctl_t;

    localparam ctl_t       CTL_NOP    = '0;
    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    state_t     state_q;
    ctl_t       ctl_q;
    ctl_t       ctl_d;
    logic [2:0] cnt_q;
    logic       branch_q;
    logic       exc_q;
    logic       halted_q;
    logic       flush_q;
    logic       pcw_q;
    logic       ifw_q;

    logic       illegal;
    logic       is_halt;
    logic       taken;
    logic       load_use;

    always_comb begin
        ctl_d   = CTL_NOP;
        illegal = 1'b0;
        is_halt = 1'b0;
        taken   = 1'b0;
        if ((opcode >> 4) != '0) begin
            illegal = 1'b1;
        end else begin
            case (opcode[3:0])
                4'b0000: begin
                    if (funct > FN_W'(7)) begin
                        illegal = 1'b1;
                    end else begin
                        ctl_d.aluop    = funct[1:0];
                        ctl_d.regwrite = 2'b01;
                    end
                end
                4'b0001, 4'b0010: begin
                    ctl_d.alusrc2   = 1'b1;
                    ctl_d.upperzero = 1'b1;
                    ctl_d.regwrite  = 2'b01;
                    ctl_d.aluop     = (opcode[1:0] == 2'b01) ? 2'b10 : 2'b11;
                end
                4'b0100: taken = (cmp == 2'b01);
                4'b0101: taken = (cmp == 2'b10);
                4'b0110: taken = (cmp == 2'b11);
                4'b0111: taken = 1'b1;
                4'b1010, 4'b1100: begin
                    ctl_d.alusrc1  = 1'b1;
                    ctl_d.alusrc2  = 1'b1;
                    ctl_d.memread  = 1'b1;
                    ctl_d.memtoreg = 1'b1;
                    ctl_d.signext  = 2'b01;
                    ctl_d.regwrite = opcode[2] ? 2'b01 : 2'b10;
                end
                4'b1011, 4'b1101: begin
                    ctl_d.alusrc1  = 1'b1;
                    ctl_d.alusrc2  = 1'b1;
                    ctl_d.memwrite = 1'b1;
                    ctl_d.strbyte  = ~opcode[2];
                    ctl_d.signext  = 2'b01;
                end
                4'b1111: is_halt = 1'b1;
                default: illegal = 1'b1;
            endcase
        end
    end

    // Hazard uses the bundle already issued to EX, i.e. the registered outputs.
    assign load_use = ctl_q.memread && (ex_rd != '0) && ((ex_rd == id_rs) || (ex_rd == id_rt));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_RUN;
            ctl_q    <= CTL_NOP;
            cnt_q    <= '0;
            branch_q <= 1'b0;
            exc_q    <= 1'b0;
            halted_q <= 1'b0;
            flush_q  <= 1'b0;
            pcw_q    <= 1'b1;
            ifw_q    <= 1'b1;
        end else begin
            ctl_q    <= CTL_NOP;
            branch_q <= 1'b0;
            case (state_q)
                // The stall cycle's exit edge re-decodes the held IF/ID instruction.
                S_RUN, S_STALL: begin
                    state_q <= S_RUN;
                    pcw_q   <= 1'b1;
                    ifw_q   <= 1'b1;
                    flush_q <= 1'b0;
                    if (instr_valid) begin
                        if (illegal) begin
                            state_q <= S_EXC;
                            exc_q   <= 1'b1;
                            pcw_q   <= 1'b0;
                            ifw_q   <= 1'b0;
                        end else if (is_halt) begin
                            state_q  <= S_HALTED;
                            halted_q <= 1'b1;
                            pcw_q    <= 1'b0;
                            ifw_q    <= 1'b0;
                        end else if (load_use) begin
                            state_q <= S_STALL;
                            pcw_q   <= 1'b0;
                            ifw_q   <= 1'b0;
                        end else if (taken) begin
                            state_q  <= S_FLUSH;
                            branch_q <= 1'b1;
                            flush_q  <= 1'b1;
                            cnt_q    <= FLUSH_INIT;
                        end else begin
                            ctl_q <= ctl_d;
                        end
                    end
                end
                S_FLUSH: begin
                    if (cnt_q == '0) begin
                        state_q <= S_RUN;
                        flush_q <= 1'b0;
                    end else begin
                        cnt_q   <= cnt_q - 3'd1;
                        flush_q <= 1'b1;
                    end
                end
                S_EXC: begin
                    if (exc_ack) begin
                        state_q <= S_RUN;
                        exc_q   <= 1'b0;
                        pcw_q   <= 1'b1;
                        ifw_q   <= 1'b1;
                    end
                end
                S_HALTED: begin
                    state_q <= S_HALTED;
                end
                default: begin
                    state_q <= S_RUN;
                end
            endcase
        end
    end

    assign ctl_alusrc1   = ctl_q.alusrc1;
    assign ctl_alusrc2   = ctl_q.alusrc2;
    assign ctl_memread   = ctl_q.memread;
    assign ctl_memwrite  = ctl_q.memwrite;
    assign ctl_memtoreg  = ctl_q.memtoreg;
    assign ctl_strbyte   = ctl_q.strbyte;
    assign ctl_upperzero = ctl_q.upperzero;
    assign ctl_aluop     = ctl_q.aluop;
    assign ctl_regwrite  = ctl_q.regwrite;
    assign ctl_signext   = ctl_q.signext;
    assign pc_write      = pcw_q;
    assign ifid_write    = ifw_q;
    assign ifid_flush    = flush_q;
    assign branch        = branch_q;
    assign exception     = exc_q;
    assign halted        = halted_q;

endmodule

// File: tb/tb_pipelined_main_control.sv
// Scoreboard bench for pipelined_main_control: each scenario queues expected
// {bundle, status} per cycle and compares after the registering edge.
module tb_pipelined_main_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       instr_valid;
    logic [3:0] opcode;
    logic [3:0] funct;
    logic [1:0] cmp;
    logic [3:0] id_rs;
    logic [3:0] id_rt;
    logic [3:0] ex_rd;
    logic       exc_ack;
    logic       ctl_alusrc1, ctl_alusrc2, ctl_memread, ctl_memwrite;
    logic       ctl_memtoreg, ctl_strbyte, ctl_upperzero;
    logic [1:0] ctl_aluop, ctl_regwrite, ctl_signext;
    logic       pc_write, ifid_write, ifid_flush, branch, exception, halted;

    pipelined_main_control #(
        .OP_W(4),
        .FN_W(4),
        .RA_W(4),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid),
        .opcode(opcode), .funct(funct), .cmp(cmp),
        .id_rs(id_rs), .id_rt(id_rt), .ex_rd(ex_rd), .exc_ack(exc_ack),
        .ctl_alusrc1(ctl_alusrc1), .ctl_alusrc2(ctl_alusrc2),
        .ctl_memread(ctl_memread), .ctl_memwrite(ctl_memwrite),
        .ctl_memtoreg(ctl_memtoreg), .ctl_strbyte(ctl_strbyte),
        .ctl_upperzero(ctl_upperzero), .ctl_aluop(ctl_aluop),
        .ctl_regwrite(ctl_regwrite), .ctl_signext(ctl_signext),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .branch(branch), .exception(exception), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst_n;
        logic       valid;
        logic [3:0] op;
        logic [3:0] fn;
        logic [1:0] cmp;
        logic [3:0] rs;
        logic [3:0] rt;
        logic [3:0] rd;
        logic       ack;
    } stim_t;

    // status = {pc_write, ifid_write, ifid_flush, branch, exception, halted}
    localparam logic [5:0]  ST_RUN   = 6'b110000;
    localparam logic [5:0]  ST_BR    = 6'b111100;
    localparam logic [5:0]  ST_FL    = 6'b111000;
    localparam logic [5:0]  ST_STALL = 6'b000000;
    localparam logic [5:0]  ST_EXC   = 6'b000010;
    localparam logic [5:0]  ST_HALT  = 6'b000001;
    localparam logic [12:0] NOP      = 13'b0;

    localparam logic [3:0] OP_R = 4'h0, OP_ANDI = 4'h1, OP_ORI = 4'h2, OP_BLT = 4'h4;
    localparam logic [3:0] OP_BGT = 4'h5, OP_BEQ = 4'h6, OP_JMP = 4'h7, OP_LB = 4'hA;
    localparam logic [3:0] OP_SB = 4'hB, OP_LW = 4'hC, OP_SW = 4'hD, OP_HALT = 4'hF;

    logic [18:0] obs;
    assign obs = {ctl_alusrc1, ctl_alusrc2, ctl_memread, ctl_memwrite, ctl_memtoreg,
                  ctl_strbyte, ctl_upperzero, ctl_aluop, ctl_regwrite, ctl_signext,
                  pc_write, ifid_write, ifid_flush, branch, exception, halted};

    logic [18:0] sb[$];
    int total = 0;
    int bad   = 0;

    // Expected bundle {alusrc1,alusrc2,memread,memwrite,memtoreg,strbyte,upperzero,aluop,regwrite,signext}
    function automatic logic [12:0] model(input logic [3:0] op, input logic [3:0] fn);
        case (op)
            OP_R:    return {7'b0000000, fn[1:0], 2'b01, 2'b00};
            OP_ANDI: return {7'b0100001, 2'b10, 2'b01, 2'b00};
            OP_ORI:  return {7'b0100001, 2'b11, 2'b01, 2'b00};
            OP_LB:   return {7'b1110100, 2'b00, 2'b10, 2'b01};
            OP_SB:   return {7'b1101010, 2'b00, 2'b00, 2'b01};
            OP_LW:   return {7'b1110100, 2'b00, 2'b01, 2'b01};
            OP_SW:   return {7'b1101000, 2'b00, 2'b00, 2'b01};
            default: return NOP;
        endcase
    endfunction

    function automatic stim_t S(input logic r, input logic v, input logic [3:0] op,
                                input logic [3:0] fn, input logic [1:0] c, input logic [3:0] rs,
                                input logic [3:0] rt, input logic [3:0] rd, input logic ack);
        stim_t s;
        s = '{rst_n: r, valid: v, op: op, fn: fn, cmp: c, rs: rs, rt: rt, rd: rd, ack: ack};
        return s;
    endfunction

    task automatic drive(input stim_t s);
        rst_n       = s.rst_n;
        instr_valid = s.valid;
        opcode      = s.op;
        funct       = s.fn;
        cmp         = s.cmp;
        id_rs       = s.rs;
        id_rt       = s.rt;
        ex_rd       = s.rd;
        exc_ack     = s.ack;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        stim_t s[$];
        logic [18:0] e[$];
        logic [18:0] want;
        s.push_back(S(0, 1, OP_BEQ, 0, 2'b11, 0, 0, 0, 0)); e.push_back({NOP, ST_RUN});
        s.push_back(S(0, 1, OP_BEQ, 0, 2'b11, 0, 0, 0, 0)); e.push_back({NOP, ST_RUN});
        s.push_back(S(1, 0, 4'h8, 0, 2'b00, 0, 0, 0, 0));   e.push_back({NOP, ST_RUN});
        s.push_back(S(1, 0, OP_LW, 0, 2'b00, 0, 0, 0, 0));  e.push_back({NOP, ST_RUN});
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            sb.push_back(e[i]);
            tick();
            want = sb.pop_front();
            total++;
            if (obs !== want) begin
                bad++;
                $display("FAIL reset step %0d: got ctl=%b st=%b, want ctl=%b st=%b",
                         i, obs[18:6], obs[5:0], want[18:6], want[5:0]);
            end
        end
    endtask

    task automatic test_decode();
        stim_t s[$];
        logic [18:0] e[$];
        logic [18:0] want;
        logic [3:0] ops[6];
        logic [3:0] fns[5];
        ops = '{OP_ANDI, OP_ORI, OP_LB, OP_SB, OP_LW, OP_SW};
        fns = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd7};
        foreach (fns[k]) begin
            s.push_back(S(1, 1, OP_R, fns[k], 2'b00, 4'd1, 4'd2, 4'd0, 0));
            e.push_back({model(OP_R, fns[k]), ST_RUN});
        end
        foreach (ops[k]) begin
            s.push_back(S(1, 1, ops[k], 4'h0, 2'b00, 4'd1, 4'd2, 4'd0, 0));
            e.push_back({model(ops[k], 4'h0), ST_RUN});
        end
        s.push_back(S(1, 1, OP_BGT, 0, 2'b01, 0, 0, 0, 0)); e.push_back({NOP, ST_RUN});
        s.push_back(S(1, 1, OP_BLT, 0, 2'b10, 0, 0, 0, 0)); e.push_back({NOP, ST_RUN});
        s.push_back(S(1, 1, OP_BEQ, 0, 2'b01, 0, 0, 0, 0)); e.push_back({NOP, ST_RUN});
        s.push_back(S(1, 1, OP_BLT, 0, 2'b00, 0, 0, 0, 0)); e.push_back({NOP, ST_RUN});
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            sb.push_back(e[i]);
            tick();
            want = sb.pop_front();
            total++;
            if (obs !== want) begin
                bad++;
                $display("FAIL decode step %0d op=%h: got ctl=%b st=%b, want ctl=%b st=%b",
                         i, s[i].op, obs[18:6], obs[5:0], want[18:6], want[5:0]);
            end
        end
    endtask

    task automatic test_branch();
        stim_t s[$];
        logic [18:0] e[$];
        logic [18:0] want;
        s.push_back(S(1, 1, OP_BEQ, 0, 2'b11, 0, 0, 0, 0));  e.push_back({NOP, ST_BR});
        s.push_back(S(1, 1, OP_BEQ, 0, 2'b11, 0, 0, 0, 0));  e.push_back({NOP, ST_FL});
        s.push_back(S(1, 1, OP_BEQ, 0, 2'b11, 0, 0, 0, 0));  e.push_back({NOP, ST_RUN});
        s.push_back(S(1, 1, OP_ORI, 0, 2'b00, 0, 0, 0, 0));  e.push_back({model(OP_ORI, 0), ST_RUN});
        s.push_back(S(1, 1, OP_JMP, 0, 2'b00, 0, 0, 0, 0));  e.push_back({NOP, ST_BR});
        s.push_back(S(1, 1, OP_ANDI, 0, 2'b00, 0, 0, 0, 0)); e.push_back({NOP, ST_FL});
        s.push_back(S(1, 1, OP_ANDI, 0, 2'b00, 0, 0, 0, 0)); e.push_back({NOP, ST_RUN});
        s.push_back(S(1, 1, OP_ANDI, 0, 2'b00, 0, 0, 0, 0)); e.push_back({model(OP_ANDI, 0), ST_RUN});
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            sb.push_back(e[i]);
            tick();
            want = sb.pop_front();
            total++;
            if (obs !== want) begin
                bad++;
                $display("FAIL branch step %0d: got ctl=%b st=%b, want ctl=%b st=%b",
                         i, obs[18:6], obs[5:0], want[18:6], want[5:0]);
            end
        end
    endtask

    task automatic test_load_use();
        stim_t s[$];
        logic [18:0] e[$];
        logic [18:0] want;
        s.push_back(S(1, 1, OP_LW, 0, 2'b00, 0, 0, 0, 0));  e.push_back({model(OP_LW, 0), ST_RUN});
        s.push_back(S(1, 1, OP_R, 1, 2'b00, 3, 0, 3, 0));   e.push_back({NOP, ST_STALL});
        s.push_back(S(1, 1, OP_R, 1, 2'b00, 3, 0, 3, 0));   e.push_back({model(OP_R, 1), ST_RUN});
        s.push_back(S(1, 1, OP_LW, 0, 2'b00, 0, 0, 3, 0));  e.push_back({model(OP_LW, 0), ST_RUN});
        s.push_back(S(1, 1, OP_R, 2, 2'b00, 0, 3, 3, 0));   e.push_back({NOP, ST_STALL});
        s.push_back(S(1, 1, OP_R, 2, 2'b00, 0, 3, 3, 0));   e.push_back({model(OP_R, 2), ST_RUN});
        s.push_back(S(1, 1, OP_LW, 0, 2'b00, 0, 0, 0, 0));  e.push_back({model(OP_LW, 0), ST_RUN});
        s.push_back(S(1, 1, OP_R, 3, 2'b00, 0, 0, 0, 0));   e.push_back({model(OP_R, 3), ST_RUN});
        s.push_back(S(1, 1, OP_LB, 0, 2'b00, 0, 0, 0, 0));  e.push_back({model(OP_LB, 0), ST_RUN});
        s.push_back(S(1, 1, OP_SW, 0, 2'b00, 4, 5, 6, 0));  e.push_back({model(OP_SW, 0), ST_RUN});
        s.push_back(S(1, 1, OP_LW, 0, 2'b00, 0, 0, 0, 0));  e.push_back({model(OP_LW, 0), ST_RUN});
        s.push_back(S(1, 1, OP_BEQ, 0, 2'b11, 3, 0, 3, 0)); e.push_back({NOP, ST_STALL});
        s.push_back(S(1, 1, OP_BEQ, 0, 2'b11, 3, 0, 3, 0)); e.push_back({NOP, ST_BR});
        s.push_back(S(1, 1, OP_BEQ, 0, 2'b11, 3, 0, 3, 0)); e.push_back({NOP, ST_FL});
        s.push_back(S(1, 1, OP_BEQ, 0, 2'b11, 3, 0, 3, 0)); e.push_back({NOP, ST_RUN});
        s.push_back(S(1, 1, OP_ANDI, 0, 2'b00, 0, 0, 0, 0)); e.push_back({model(OP_ANDI, 0), ST_RUN});
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            sb.push_back(e[i]);
            tick();
            want = sb.pop_front();
            total++;
            if (obs !== want) begin
                bad++;
                $display("FAIL load_use step %0d: got ctl=%b st=%b, want ctl=%b st=%b",
                         i, obs[18:6], obs[5:0], want[18:6], want[5:0]);
            end
        end
    endtask

    task automatic test_illegal();
        stim_t s[$];
        logic [18:0] e[$];
        logic [18:0] want;
        s.push_back(S(1, 1, OP_LW, 0, 2'b00, 0, 0, 0, 0));   e.push_back({model(OP_LW, 0), ST_RUN});
        s.push_back(S(1, 1, 4'h8, 0, 2'b00, 3, 0, 3, 0));    e.push_back({NOP, ST_EXC});
        s.push_back(S(1, 1, OP_ANDI, 0, 2'b00, 0, 0, 0, 0)); e.push_back({NOP, ST_EXC});
        s.push_back(S(1, 1, OP_ANDI, 0, 2'b00, 0, 0, 0, 1)); e.push_back({NOP, ST_RUN});
        s.push_back(S(1, 1, OP_ANDI, 0, 2'b00, 0, 0, 0, 0)); e.push_back({model(OP_ANDI, 0), ST_RUN});
        s.push_back(S(1, 1, OP_R, 4'h8, 2'b00, 0, 0, 0, 0)); e.push_back({NOP, ST_EXC});
        s.push_back(S(1, 1, OP_R, 4'h0, 2'b00, 0, 0, 0, 1)); e.push_back({NOP, ST_RUN});
        s.push_back(S(1, 1, OP_R, 4'h0, 2'b00, 0, 0, 0, 0)); e.push_back({model(OP_R, 0), ST_RUN});
        s.push_back(S(1, 1, 4'h3, 0, 2'b00, 0, 0, 0, 0));    e.push_back({NOP, ST_EXC});
        s.push_back(S(1, 1, OP_BEQ, 0, 2'b11, 0, 0, 0, 1));  e.push_back({NOP, ST_RUN});
        s.push_back(S(1, 1, OP_ORI, 0, 2'b00, 0, 0, 0, 0));  e.push_back({model(OP_ORI, 0), ST_RUN});
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            sb.push_back(e[i]);
            tick();
            want = sb.pop_front();
            total++;
            if (obs !== want) begin
                bad++;
                $display("FAIL illegal step %0d: got ctl=%b st=%b, want ctl=%b st=%b",
                         i, obs[18:6], obs[5:0], want[18:6], want[5:0]);
            end
        end
    endtask

    task automatic test_halt();
        stim_t s[$];
        logic [18:0] e[$];
        logic [18:0] want;
        s.push_back(S(1, 1, OP_HALT, 0, 2'b00, 0, 0, 0, 0)); e.push_back({NOP, ST_HALT});
        s.push_back(S(1, 1, OP_BEQ, 0, 2'b11, 0, 0, 0, 0));  e.push_back({NOP, ST_HALT});
        s.push_back(S(1, 1, 4'h8, 0, 2'b00, 0, 0, 0, 1));    e.push_back({NOP, ST_HALT});
        s.push_back(S(1, 1, OP_LW, 0, 2'b00, 0, 0, 0, 0));   e.push_back({NOP, ST_HALT});
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            sb.push_back(e[i]);
            tick();
            want = sb.pop_front();
            total++;
            if (obs !== want) begin
                bad++;
                $display("FAIL halt step %0d: got ctl=%b st=%b, want ctl=%b st=%b",
                         i, obs[18:6], obs[5:0], want[18:6], want[5:0]);
            end
        end
    endtask

    task automatic test_reset_mid_event();
        stim_t s[$];
        logic [18:0] e[$];
        logic [18:0] want;
        s.push_back(S(0, 1, OP_HALT, 0, 2'b00, 0, 0, 0, 0)); e.push_back({NOP, ST_RUN});
        s.push_back(S(1, 1, OP_BEQ, 0, 2'b11, 0, 0, 0, 0));  e.push_back({NOP, ST_BR});
        s.push_back(S(0, 1, OP_BEQ, 0, 2'b11, 0, 0, 0, 0));  e.push_back({NOP, ST_RUN});
        s.push_back(S(1, 1, OP_SW, 0, 2'b00, 0, 0, 0, 0));   e.push_back({model(OP_SW, 0), ST_RUN});
        s.push_back(S(1, 1, OP_LW, 0, 2'b00, 0, 0, 0, 0));   e.push_back({model(OP_LW, 0), ST_RUN});
        s.push_back(S(1, 1, OP_R, 1, 2'b00, 3, 0, 3, 0));    e.push_back({NOP, ST_STALL});
        s.push_back(S(0, 1, OP_R, 1, 2'b00, 3, 0, 3, 0));    e.push_back({NOP, ST_RUN});
        s.push_back(S(1, 1, OP_R, 1, 2'b00, 3, 0, 3, 0));    e.push_back({model(OP_R, 1), ST_RUN});
        s.push_back(S(1, 1, 4'h9, 0, 2'b00, 0, 0, 0, 0));    e.push_back({NOP, ST_EXC});
        s.push_back(S(0, 1, OP_ORI, 0, 2'b00, 0, 0, 0, 0));  e.push_back({NOP, ST_RUN});
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            sb.push_back(e[i]);
            tick();
            want = sb.pop_front();
            total++;
            if (obs !== want) begin
                bad++;
                $display("FAIL reset_mid step %0d: got ctl=%b st=%b, want ctl=%b st=%b",
                         i, obs[18:6], obs[5:0], want[18:6], want[5:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_branch();
        test_load_use();
        test_illegal();
        test_halt();
        test_reset_mid_event();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
